// File: rtl/hit_event_manager.sv
// -----------------------------------------------------------------------------
// hit_event_manager
//
// Purpose:
//   Sits downstream of the collision detector and the VGA object drawers.
//   Overlap events seen on any pixel of a frame are latched.
//   They are resolved once per frame, on the startOfFrame cycle (the "commit").
//   The commit produces one-cycle remove/hit pulses for the projectile, banana
//   and spaceship movers. It also maintains the score, the lives, ship
//   invulnerability and the play/game-over state.
//
// Ports:
//   clk                        in   system clock
//   resetN                     in   asynchronous, active-low reset
//   startOfFrame               in   one-cycle pulse per frame; commit cycle
//   start_game                 in   start request, sampled only at commit
//   collision                  in   projectile vs border/shield
//   collisionBanana            in   banana vs border/ship/shield
//   drawing_request_spaceship  in   ship pixel active
//   drawing_request_projectile in   projectile pixel active
//   drawing_request_monster    in   monster pixel active
//   projectile_remove          out  one-cycle pulse, projectile must be removed
//   banana_remove              out  one-cycle pulse, banana must be removed
//   ship_hit                   out  one-cycle pulse, ship lost a life
//   monster_hit                out  one-cycle pulse, a monster was hit
//   score        [SCORE_W]     out  accumulated score, saturating
//   lives        [LIVES_W]     out  remaining lives
//   ship_blink                 out  high in invulnerability on counter bit 2
//   game_over                  out  high in the OVER state
//
// All outputs are registered. The results of a commit become visible on the
// cycle after startOfFrame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module hit_event_manager #(
  parameter int INIT_LIVES     = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int MONSTER_POINTS = 10,
  parameter int SCORE_W        = 16,
  parameter int LIVES_W        = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               collision,
  input  logic               collisionBanana,
  input  logic               drawing_request_spaceship,
  input  logic               drawing_request_projectile,
  input  logic               drawing_request_monster,
  output logic               projectile_remove,
  output logic               banana_remove,
  output logic               ship_hit,
  output logic               monster_hit,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               ship_blink,
  output logic               game_over
);

  localparam int SCORE_EXT_W = SCORE_W + 1;
  localparam logic [SCORE_EXT_W-1:0] POINTS_EXT  = SCORE_EXT_W'(MONSTER_POINTS);
  localparam logic [LIVES_W-1:0]     LIVES_INIT  = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0]     LIVES_ONE   = LIVES_W'(1);
  localparam logic [7:0]             INVULN_INIT = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           invulnCnt_q, invulnCnt_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;

  logic                 evProj_q, evProj_d;
  logic                 evBan_q, evBan_d;
  logic                 evShip_q, evShip_d;
  logic                 evMon_q, evMon_d;

  logic                 projRemove_q, projRemove_d;
  logic                 banRemove_q, banRemove_d;
  logic                 shipHit_q, shipHit_d;
  logic                 monHit_q, monHit_d;
  logic                 blink_q, blink_d;
  logic                 over_q, over_d;

  logic                 frameProj, frameBan, frameShip, frameMon;
  logic [SCORE_EXT_W-1:0] scoreSum;
  logic [SCORE_W-1:0]   scoreSat;

  // Each frame event is the sticky latch OR'ed with this cycle's condition.
  // An overlap that occurs on the commit cycle itself is therefore included
  // in that commit and is not carried into the next frame.
  always_comb begin
    frameProj = evProj_q | collision;
    frameBan  = evBan_q  | collisionBanana;
    frameShip = evShip_q | (collisionBanana & drawing_request_spaceship);
    frameMon  = evMon_q  | (drawing_request_projectile & drawing_request_monster);
  end

  // The score is computed one bit wider so that an overflow can be detected.
  // On overflow the score clamps to all-ones instead of wrapping.
  always_comb begin
    scoreSum = {1'b0, score_q} + POINTS_EXT;
    scoreSat = scoreSum[SCORE_W] ? {SCORE_W{1'b1}} : scoreSum[SCORE_W-1:0];
  end

  // Next-state logic. Between commits, the latches only accumulate and the
  // pulses drop back to zero. On a commit, the latches are cleared and the
  // frame's events are resolved according to the current game state.
  always_comb begin
    state_d      = state_q;
    invulnCnt_d  = invulnCnt_q;
    score_d      = score_q;
    lives_d      = lives_q;
    evProj_d     = frameProj;
    evBan_d      = frameBan;
    evShip_d     = frameShip;
    evMon_d      = frameMon;
    projRemove_d = 1'b0;
    banRemove_d  = 1'b0;
    shipHit_d    = 1'b0;
    monHit_d     = 1'b0;

    if (startOfFrame) begin
      evProj_d = 1'b0;
      evBan_d  = 1'b0;
      evShip_d = 1'b0;
      evMon_d  = 1'b0;

      case (state_q)
        IDLE, OVER: begin
          // Latched events are discarded here. Only a start request matters.
          if (start_game) begin
            state_d     = PLAY;
            score_d     = '0;
            lives_d     = LIVES_INIT;
            invulnCnt_d = '0;
          end
        end

        PLAY, INVULN: begin
          projRemove_d = frameProj | frameMon;
          banRemove_d  = frameBan;
          monHit_d     = frameMon;
          if (frameMon) begin
            score_d = scoreSat;
          end

          if (state_q == INVULN) begin
            // While invulnerable, a ship overlap only removes the banana
            // (banRemove_d above). The counter counts commits down to zero.
            invulnCnt_d = invulnCnt_q - 8'd1;
            if (invulnCnt_q == 8'd1) begin
              state_d = PLAY;
            end
          end else if (frameShip && (lives_q != '0)) begin
            // The score update above still lands in this commit, even when
            // this hit ends the game.
            shipHit_d = 1'b1;
            lives_d   = lives_q - LIVES_ONE;
            if (lives_q == LIVES_ONE) begin
              state_d = OVER;
            end else begin
              state_d     = INVULN;
              invulnCnt_d = INVULN_INIT;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // These level outputs are derived from the next state, so that they are
    // registered together with the state.
    blink_d = (state_d == INVULN) & invulnCnt_d[2];
    over_d  = (state_d == OVER);
  end

  // All state and output registers. An asynchronous reset returns everything
  // to the idle, fresh-game values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      invulnCnt_q  <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      evProj_q     <= 1'b0;
      evBan_q      <= 1'b0;
      evShip_q     <= 1'b0;
      evMon_q      <= 1'b0;
      projRemove_q <= 1'b0;
      banRemove_q  <= 1'b0;
      shipHit_q    <= 1'b0;
      monHit_q     <= 1'b0;
      blink_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      invulnCnt_q  <= invulnCnt_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      evProj_q     <= evProj_d;
      evBan_q      <= evBan_d;
      evShip_q     <= evShip_d;
      evMon_q      <= evMon_d;
      projRemove_q <= projRemove_d;
      banRemove_q  <= banRemove_d;
      shipHit_q    <= shipHit_d;
      monHit_q     <= monHit_d;
      blink_q      <= blink_d;
      over_q       <= over_d;
    end
  end

  assign projectile_remove = projRemove_q;
  assign banana_remove     = banRemove_q;
  assign ship_hit          = shipHit_q;
  assign monster_hit       = monHit_q;
  assign score             = score_q;
  assign lives             = lives_q;
  assign ship_blink        = blink_q;
  assign game_over         = over_q;

endmodule

// File: tb/tb_hit_event_manager.sv
// -----------------------------------------------------------------------------
// tb_hit_event_manager
//
// Purpose:
//   Self-checking bench for hit_event_manager.
//   A frame-level behavioural model predicts every output on every cycle.
//   Directed scenarios and a randomized phase drive the DUT.
//   A few hand-computed literal values pin the model itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hit_event_manager;

  localparam int INIT_LIVES     = 3;
  localparam int INVULN_FRAMES  = 60;
  localparam int MONSTER_POINTS = 10;
  localparam int SCORE_MAX      = 65535;

  localparam int M_IDLE   = 0;
  localparam int M_PLAY   = 1;
  localparam int M_INVULN = 2;
  localparam int M_OVER   = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        start_game = 1'b0;
  logic        collision = 1'b0;
  logic        collisionBanana = 1'b0;
  logic        drawing_request_spaceship = 1'b0;
  logic        drawing_request_projectile = 1'b0;
  logic        drawing_request_monster = 1'b0;
  logic        projectile_remove;
  logic        banana_remove;
  logic        ship_hit;
  logic        monster_hit;
  logic [15:0] score;
  logic [2:0]  lives;
  logic        ship_blink;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  hit_event_manager #(
    .INIT_LIVES(INIT_LIVES),
    .INVULN_FRAMES(INVULN_FRAMES),
    .MONSTER_POINTS(MONSTER_POINTS),
    .SCORE_W(16),
    .LIVES_W(3)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .start_game(start_game),
    .collision(collision),
    .collisionBanana(collisionBanana),
    .drawing_request_spaceship(drawing_request_spaceship),
    .drawing_request_projectile(drawing_request_projectile),
    .drawing_request_monster(drawing_request_monster),
    .projectile_remove(projectile_remove),
    .banana_remove(banana_remove),
    .ship_hit(ship_hit),
    .monster_hit(monster_hit),
    .score(score),
    .lives(lives),
    .ship_blink(ship_blink),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Behavioural model state. It tracks whether anything happened during the
  // frame, the game state, score, lives and the number of invulnerable
  // frames left. It also holds the pulses expected after the latest clock.
  int mState = M_IDLE;
  int mScore = 0;
  int mLives = INIT_LIVES;
  int mInvLeft = 0;
  bit sawProj = 0, sawBan = 0, sawShip = 0, sawMon = 0;
  bit fProj, fBan, fShip, fMon;
  bit expProjRem = 0, expBanRem = 0, expShipHit = 0, expMonHit = 0;

  task automatic modelReset();
    mState = M_IDLE;
    mScore = 0;
    mLives = INIT_LIVES;
    mInvLeft = 0;
    sawProj = 0; sawBan = 0; sawShip = 0; sawMon = 0;
    expProjRem = 0; expBanRem = 0; expShipHit = 0; expMonHit = 0;
  endtask

  // Model update: runs on every clock edge and on an asynchronous reset.
  initial begin
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        modelReset();
      end else begin
        fProj = sawProj | collision;
        fBan  = sawBan  | collisionBanana;
        fShip = sawShip | (collisionBanana & drawing_request_spaceship);
        fMon  = sawMon  | (drawing_request_projectile & drawing_request_monster);
        expProjRem = 0; expBanRem = 0; expShipHit = 0; expMonHit = 0;
        if (startOfFrame) begin
          sawProj = 0; sawBan = 0; sawShip = 0; sawMon = 0;
          if (mState == M_IDLE || mState == M_OVER) begin
            if (start_game) begin
              mState = M_PLAY;
              mScore = 0;
              mLives = INIT_LIVES;
            end
          end else begin
            expProjRem = fProj | fMon;
            expBanRem  = fBan;
            expMonHit  = fMon;
            if (fMon) mScore = (mScore + MONSTER_POINTS > SCORE_MAX) ? SCORE_MAX : mScore + MONSTER_POINTS;
            if (mState == M_INVULN) begin
              mInvLeft = mInvLeft - 1;
              if (mInvLeft == 0) mState = M_PLAY;
            end else if (fShip && mLives > 0) begin
              expShipHit = 1;
              mLives = mLives - 1;
              if (mLives == 0) begin
                mState = M_OVER;
              end else begin
                mState = M_INVULN;
                mInvLeft = INVULN_FRAMES;
              end
            end
          end
        end else begin
          sawProj = fProj; sawBan = fBan; sawShip = fShip; sawMon = fMon;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle, 1 ns after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (checkEn) begin
        checkOutput("projectile_remove", 32'(projectile_remove), 32'(expProjRem));
        checkOutput("banana_remove", 32'(banana_remove), 32'(expBanRem));
        checkOutput("ship_hit", 32'(ship_hit), 32'(expShipHit));
        checkOutput("monster_hit", 32'(monster_hit), 32'(expMonHit));
        checkOutput("score", 32'(score), 32'(mScore));
        checkOutput("lives", 32'(lives), 32'(mLives));
        checkOutput("ship_blink", 32'(ship_blink), 32'((mState == M_INVULN) && mInvLeft[2]));
        checkOutput("game_over", 32'(game_over), 32'(mState == M_OVER));
      end
    end
  end

  task automatic applyStimulus(input bit sof, input bit st, input bit col, input bit colB,
                               input bit ship, input bit proj, input bit mon);
    @(negedge clk);
    startOfFrame = sof;
    start_game = st;
    collision = col;
    collisionBanana = colB;
    drawing_request_spaceship = ship;
    drawing_request_projectile = proj;
    drawing_request_monster = mon;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One event cycle, then a commit cycle; then wait for its results.
  task automatic frame(input bit st, input bit col, input bit colB, input bit ship,
                       input bit proj, input bit mon);
    applyStimulus(0, 0, col, colB, ship, proj, mon);
    applyStimulus(1, st, 0, 0, 0, 0, 0);
    settle();
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 0; start_game = 0; collision = 0; collisionBanana = 0;
    drawing_request_spaceship = 0; drawing_request_projectile = 0; drawing_request_monster = 0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit rSof;
    // Reset values.
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    checkEn = 1'b1;
    settle();
    checkOutput("reset score", 32'(score), 0);
    checkOutput("reset lives", 32'(lives), 3);
    checkOutput("reset game_over", 32'(game_over), 0);

    // Start the game.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    settle();
    checkOutput("start lives", 32'(lives), 3);
    checkOutput("start score", 32'(score), 0);
    checkOutput("start game_over", 32'(game_over), 0);

    // Five cycles of projectile/monster overlap in one frame: a single hit.
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idleInputs();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("mon score", 32'(score), 10);
    checkOutput("mon pulse", 32'(monster_hit), 1);
    idleInputs();
    settle();
    checkOutput("mon pulse end", 32'(monster_hit), 0);

    // Ship hit, then a second hit while still invulnerable.
    frame(0, 0, 1, 1, 0, 0);
    checkOutput("hit1 lives", 32'(lives), 2);
    checkOutput("hit1 ship_hit", 32'(ship_hit), 1);
    checkOutput("hit1 blink", 32'(ship_blink), 1);
    frame(0, 0, 0, 0, 0, 0);
    checkOutput("blink toggled", 32'(ship_blink), 0);
    frame(0, 0, 1, 1, 0, 0);
    checkOutput("invuln lives", 32'(lives), 2);
    checkOutput("invuln banana", 32'(banana_remove), 1);
    checkOutput("invuln no ship_hit", 32'(ship_hit), 0);

    // Three well-spaced hits end the game; monster hits then score nothing.
    doReset();
    frame(1, 0, 0, 0, 0, 0);
    for (int h = 0; h < 3; h++) begin
      frame(0, 0, 1, 1, 0, 0);
      repeat (INVULN_FRAMES + 1) frame(0, 0, 0, 0, 0, 0);
    end
    checkOutput("over lives", 32'(lives), 0);
    checkOutput("over game_over", 32'(game_over), 1);
    frame(0, 0, 0, 0, 1, 1);
    checkOutput("over score frozen", 32'(score), 0);

    // An event on the commit cycle itself counts once and is not repeated.
    frame(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    settle();
    checkOutput("sof-event pulse", 32'(monster_hit), 1);
    checkOutput("sof-event score", 32'(score), 10);
    frame(0, 0, 0, 0, 0, 0);
    checkOutput("sof-event no repeat", 32'(monster_hit), 0);

    // Randomized frames, with occasional resets and consecutive commits.
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      for (int c = $urandom_range(0, 5); c > 0; c--) begin
        applyStimulus(0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0);
      end
      rSof = 1'b1;
      applyStimulus(rSof, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
    end
    idleInputs();

    // Score saturation through back-to-back commits, then reset mid-INVULN.
    doReset();
    frame(1, 0, 0, 0, 0, 0);
    repeat (6554) applyStimulus(1, 0, 0, 0, 0, 1, 1);
    idleInputs();
    settle();
    checkOutput("score saturated", 32'(score), 32'hFFFF);
    frame(0, 0, 1, 1, 0, 0);
    repeat (5) frame(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checkOutput("async reset score", 32'(score), 0);
    checkOutput("async reset lives", 32'(lives), 3);
    checkOutput("async reset blink", 32'(ship_blink), 0);
    checkOutput("async reset game_over", 32'(game_over), 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (4) idleInputs();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
